bloom_search_ctrl: RTL and testbench

Sequencer for the block-serial Bloom-filter page-pattern search datapath. It steps the block index across all blocks of the input vector and strobes a block load. After the comparator latency it samples the per-block page-match vector. It then packs the global indices of matching pages one per cycle into a result array with a hit count and a sticky overflow flag. It sits between the host-side start/done handshake and the comparator block, and replaces the free-running block index and separate result-collection strobe.

---
 rtl/bloom_search_ctrl.sv | 169 ++++++++++++++++
 tb/tb_bloom_search_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bloom_search_ctrl.sv
// Block-serial Bloom-filter search sequencer: steps blocks through the comparator,
// samples each block's match vector and packs matching global page indices into tpn_arr.
module bloom_search_ctrl #(
  parameter int NOB       = 3,
  parameter int PPB       = 8,
  parameter int NOP_WIDTH = 5,
  parameter int CMP_LAT   = 2,
  parameter int MAX_HITS  = 8,
  localparam int NOB_W    = (NOB > 1) ? $clog2(NOB) : 1,
  localparam int CNT_W    = $clog2(MAX_HITS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  output logic [NOB_W-1:0]              blk_idx,
  output logic                          blk_load,
  input  logic [PPB-1:0]                match_vec,
  output logic                          busy,
  output logic                          done,
  output logic [NOP_WIDTH*MAX_HITS-1:0] tpn_arr,
  output logic [CNT_W-1:0]              tpn_cnt,
  output logic                          overflow,
  output logic [2:0]                    dbg_state
);

  localparam int LAT_W = $clog2(CMP_LAT + 1);
  localparam int KW    = (PPB > 1) ? $clog2(PPB) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WAIT = 3'd2,
    S_PACK = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e                        state_q, state_d;
  logic [NOB_W-1:0]              blk_idx_q, blk_idx_d;
  logic [LAT_W-1:0]              wait_q, wait_d;
  logic [PPB-1:0]                pending_q, pending_d;
  logic [NOP_WIDTH*MAX_HITS-1:0] arr_q, arr_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          ovf_q, ovf_d;

  logic [KW-1:0]                 low_k;
  logic [NOP_WIDTH-1:0]          hit_idx;
  logic [PPB-1:0]                pend_next;
  logic                          last_blk;

  // Lowest set bit first keeps the packed indices in ascending order.
  always_comb begin
    low_k = '0;
    for (int i = PPB - 1; i >= 0; i--) begin
      if (pending_q[i]) low_k = KW'(i);
    end
  end

  assign hit_idx   = NOP_WIDTH'(blk_idx_q) * NOP_WIDTH'(PPB) + NOP_WIDTH'(low_k);
  assign pend_next = pending_q & (pending_q - PPB'(1));
  assign last_blk  = (blk_idx_q == NOB_W'(NOB - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      blk_idx_q <= '0;
      wait_q    <= '0;
      pending_q <= '0;
      arr_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      blk_idx_q <= blk_idx_d;
      wait_q    <= wait_d;
      pending_q <= pending_d;
      arr_q     <= arr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  // Host handshake: start is accepted only in IDLE (abort low); done pulses for one
  // cycle on normal completion and the results are final while it is high.
  always_comb begin
    state_d   = state_q;
    blk_idx_d = blk_idx_q;
    wait_d    = wait_q;
    pending_d = pending_q;
    arr_d     = arr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    blk_load  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          arr_d     = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          blk_idx_d = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        blk_load = 1'b1;
        busy     = 1'b1;
        wait_d   = LAT_W'(CMP_LAT);
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        busy   = 1'b1;
        wait_d = wait_q - LAT_W'(1);
        if (wait_q == LAT_W'(1)) begin
          pending_d = match_vec;
          if (match_vec != '0) begin
            state_d = S_PACK;
          end else if (last_blk) begin
            state_d = S_DONE;
          end else begin
            blk_idx_d = blk_idx_q + NOB_W'(1);
            state_d   = S_LOAD;
          end
        end
      end
      S_PACK: begin
        busy = 1'b1;
        if (cnt_q < CNT_W'(MAX_HITS)) begin
          for (int i = 0; i < MAX_HITS; i++) begin
            if (cnt_q == CNT_W'(i)) arr_d[NOP_WIDTH*i +: NOP_WIDTH] = hit_idx;
          end
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
        pending_d = pend_next;
        if (pend_next == '0) begin
          if (last_blk) begin
            state_d = S_DONE;
          end else begin
            blk_idx_d = blk_idx_q + NOB_W'(1);
            state_d   = S_LOAD;
          end
        end
      end
      S_DONE: begin
        done      = 1'b1;
        blk_idx_d = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort keeps whatever results were collected so far.
    if (abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      blk_idx_d = '0;
    end
  end

  assign blk_idx   = blk_idx_q;
  assign tpn_arr   = arr_q;
  assign tpn_cnt   = cnt_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bloom_search_ctrl.sv
// Bench for bloom_search_ctrl: table of searches driven cycle by cycle, expected
// results queued at start and compared at done/abort, plus reset corner sequences.
module tb_bloom_search_ctrl;

  localparam int NOB       = 3;
  localparam int PPB       = 8;
  localparam int NOP_WIDTH = 5;
  localparam int CMP_LAT   = 2;
  localparam int MAX_HITS  = 8;
  localparam int NOB_W     = 2;
  localparam int CNT_W     = 4;
  localparam int ARR_W     = NOP_WIDTH * MAX_HITS;
  localparam int RES_W     = 1 + CNT_W + ARR_W;
  localparam int VEC_W     = NOB * PPB;
  localparam int NCASE     = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [PPB-1:0]   match_vec = '0;
  logic [NOB_W-1:0] blk_idx;
  logic             blk_load;
  logic             busy;
  logic             done;
  logic [ARR_W-1:0] tpn_arr;
  logic [CNT_W-1:0] tpn_cnt;
  logic             overflow;
  logic [2:0]       dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [RES_W-1:0] exp_q[$];

  typedef struct {
    logic [VEC_W-1:0] vecs;
    int               abort_cyc;
    int               start_cyc;
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_ovf;
    logic [ARR_W-1:0] exp_arr;
    int               exp_done;
  } case_t;

  case_t cases[NCASE];

  bloom_search_ctrl #(
    .NOB(NOB), .PPB(PPB), .NOP_WIDTH(NOP_WIDTH), .CMP_LAT(CMP_LAT), .MAX_HITS(MAX_HITS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .blk_idx(blk_idx), .blk_load(blk_load), .match_vec(match_vec),
    .busy(busy), .done(done), .tpn_arr(tpn_arr), .tpn_cnt(tpn_cnt),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk global page indices in ascending order.
  function automatic logic [RES_W-1:0] model(input logic [VEC_W-1:0] v);
    logic [ARR_W-1:0] arr;
    int cnt;
    logic ovf;
    arr = '0;
    cnt = 0;
    ovf = 1'b0;
    for (int g = 0; g < VEC_W; g++) begin
      if (v[g]) begin
        if (cnt < MAX_HITS) begin
          arr[NOP_WIDTH*cnt +: NOP_WIDTH] = NOP_WIDTH'(g);
          cnt++;
        end else begin
          ovf = 1'b1;
        end
      end
    end
    return {ovf, CNT_W'(cnt), arr};
  endfunction

  function automatic int done_cycle(input logic [VEC_W-1:0] v);
    int t;
    t = 1;
    for (int b = 0; b < NOB; b++) t += 1 + CMP_LAT + $countones(v[b*PPB +: PPB]);
    return t;
  endfunction

  task automatic compare_results(input string tag);
    logic [RES_W-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_queue: got empty expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_cnt"}, 64'(tpn_cnt), 64'(e[ARR_W +: CNT_W]));
      check({tag, "_ovf"}, 64'(overflow), 64'(e[RES_W-1]));
      check({tag, "_arr"}, 64'(tpn_arr), 64'(e[ARR_W-1:0]));
    end
  endtask

  task automatic run_case(input case_t c);
    int cyc;
    int blk;
    int t_next;
    int samp_cyc;
    int samp_blk;
    bit fin;
    exp_q.push_back({c.exp_ovf, c.exp_cnt, c.exp_arr});
    @(negedge clk);
    start = 1'b1;
    abort = 1'b0;
    match_vec = PPB'($urandom);
    cyc = 0; blk = 0; t_next = 1; samp_cyc = -1; samp_blk = 0; fin = 1'b0;
    while (!fin && cyc < 80) begin
      @(negedge clk);
      cyc++;
      start = (cyc == c.start_cyc);
      if (cyc == 1) begin
        check("clear_cnt", 64'(tpn_cnt), 64'(0));
        check("clear_ovf", 64'(overflow), 64'(0));
      end
      if (blk_load) begin
        if (blk >= NOB) begin
          check("extra_load", 64'(cyc), 64'(0));
        end else begin
          check("load_cycle", 64'(cyc), 64'(t_next));
          check("load_idx", 64'(blk_idx), 64'(blk));
          samp_cyc = cyc + CMP_LAT;
          samp_blk = blk;
          t_next = cyc + 1 + CMP_LAT + $countones(c.vecs[blk*PPB +: PPB]);
          blk++;
        end
      end
      match_vec = (cyc == samp_cyc) ? c.vecs[samp_blk*PPB +: PPB] : PPB'($urandom);
      if (done) begin
        check("done_cycle", 64'(cyc), 64'(c.exp_done));
        check("done_busy", 64'(busy), 64'(0));
        compare_results("done");
        fin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", 64'(done), 64'(0));
        check("idle_idx", 64'(blk_idx), 64'(0));
        check("idle_state", 64'(dbg_state), 64'(0));
      end else if (c.abort_cyc != 0 && cyc == c.abort_cyc + 1) begin
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_state", 64'(dbg_state), 64'(0));
        check("abort_idx", 64'(blk_idx), 64'(0));
        compare_results("abort");
        fin = 1'b1;
        abort = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("abort_no_done", 64'(done), 64'(0));
        end
      end
      abort = (c.abort_cyc != 0 && cyc == c.abort_cyc);
    end
    start = 1'b0;
    abort = 1'b0;
    if (!fin) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: got no completion expected done in cycle %0d", c.exp_done);
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    logic [RES_W-1:0] r;
    logic [ARR_W-1:0] ovf_arr;
    int pc;

    ovf_arr = '0;
    for (int i = 0; i < MAX_HITS; i++) ovf_arr[NOP_WIDTH*i +: NOP_WIDTH] = NOP_WIDTH'(i);

    cases[0] = '{vecs: 24'h000000, abort_cyc: 0, start_cyc: 0, exp_cnt: 4'd0, exp_ovf: 1'b0,
                 exp_arr: '0, exp_done: 10};
    cases[1] = '{vecs: 24'h800005, abort_cyc: 0, start_cyc: 0, exp_cnt: 4'd3, exp_ovf: 1'b0,
                 exp_arr: (40'd23 << 10) | (40'd2 << 5), exp_done: 13};
    cases[2] = '{vecs: 24'hFFFFFF, abort_cyc: 0, start_cyc: 0, exp_cnt: 4'd8, exp_ovf: 1'b1,
                 exp_arr: ovf_arr, exp_done: 34};
    cases[3] = '{vecs: 24'h000000, abort_cyc: 0, start_cyc: 5, exp_cnt: 4'd0, exp_ovf: 1'b0,
                 exp_arr: '0, exp_done: 10};
    cases[4] = '{vecs: 24'h000002, abort_cyc: 6, start_cyc: 0, exp_cnt: 4'd1, exp_ovf: 1'b0,
                 exp_arr: 40'd1, exp_done: 0};
    for (int i = 5; i < NCASE; i++) begin
      cases[i].vecs      = VEC_W'($urandom) & VEC_W'($urandom);
      cases[i].abort_cyc = 0;
      cases[i].start_cyc = (i == 6) ? $urandom_range(2, 8) : 0;
      r = model(cases[i].vecs);
      cases[i].exp_ovf   = r[RES_W-1];
      cases[i].exp_cnt   = r[ARR_W +: CNT_W];
      cases[i].exp_arr   = r[ARR_W-1:0];
      cases[i].exp_done  = done_cycle(cases[i].vecs);
    end

    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_load", 64'(blk_load), 64'(0));
    check("rst_cnt", 64'(tpn_cnt), 64'(0));
    check("rst_arr", 64'(tpn_arr), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("rst_state", 64'(dbg_state), 64'(0));

    for (int i = 0; i < NCASE; i++) run_case(cases[i]);

    // Asynchronous reset in the middle of packing a full block.
    @(negedge clk);
    match_vec = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pc = 0;
    while (dbg_state != 3'd3 && pc < 20) begin
      @(negedge clk);
      pc++;
    end
    check("reach_pack", 64'(dbg_state), 64'(3));
    @(negedge clk);
    check("pre_rst_cnt", 64'(tpn_cnt), 64'(1));
    rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_load", 64'(blk_load), 64'(0));
    check("arst_cnt", 64'(tpn_cnt), 64'(0));
    check("arst_ovf", 64'(overflow), 64'(0));
    check("arst_arr", 64'(tpn_arr), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_state", 64'(dbg_state), 64'(0));
    check("post_rst_idx", 64'(blk_idx), 64'(0));

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
